qed_consistency_checker: RTL

Observes writeback-stage register writes and retire events of the SQED-instrumented RISC-V pipeline. Keeps a shadow copy of the 32-entry register file and counts committed original and duplicate instructions. When the counts match, it scans the register pairs (x[i], x[i+16]) for i = 0..15 and reports any mismatch. It is the consumer end of the QED duplication path: the fetch stage produces original/duplicate instruction streams, and this block checks what they wrote back.

---
 rtl/qed_consistency_checker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/qed_consistency_checker.sv
// SQED consistency checker: shadows writeback register writes, counts original/duplicate
// commits and scans pairs (x[i], x[i+16]) once the counts agree. Option: QED_CHECK_STICKY_EN.
module qed_consistency_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  input  logic             commit,
  input  logic             commit_dup,
  output logic [CNT_W-1:0] orig_count,
  output logic [CNT_W-1:0] dup_count,
  output logic             cnt_ovf,
  output logic             check_busy,
  output logic             check_done,
  output logic             check_pass,
  output logic [3:0]       mismatch_idx,
  output logic             qed_error
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [31:0]       sh_q [32];
  logic [31:0]       sh_d [32];
  logic [CNT_W-1:0]  orig_q, orig_d, dup_q, dup_d;
  logic              ovf_q, ovf_d, dirty_q, dirty_d;
  logic [3:0]        idx_q, idx_d, mis_q, mis_d;
  logic              pass_q, pass_d, err_q, err_d;
  logic              trigger, activity;

  assign activity = wb_we | commit;
  assign trigger  = dirty_q && (orig_q == dup_q) && (orig_q != '0) && !ovf_q && !activity;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves a latch behind.
    sh_d    = sh_q;
    orig_d  = orig_q;
    dup_d   = dup_q;
    ovf_d   = ovf_q;
    dirty_d = dirty_q;
    state_d = state_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    pass_d  = pass_q;
    err_d   = err_q;

    if (wb_we && wb_rd != 5'd0) sh_d[wb_rd] = wb_data;
    sh_d[0] = '0;

    if (commit) begin
      if (commit_dup) begin
        if (dup_q != CNT_MAX) dup_d = dup_q + CNT_ONE;
      end else begin
        if (orig_q != CNT_MAX) orig_d = orig_q + CNT_ONE;
      end
    end
    ovf_d = ovf_q | (orig_d == CNT_MAX) | (dup_d == CNT_MAX);

    // A commit landing in the DONE cycle must keep the file marked for a rescan.
    if (state_q == ST_DONE) dirty_d = 1'b0;
    if (commit) dirty_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_SCAN;
          idx_d   = 4'd0;
        end
      end
      ST_SCAN: begin
        if (activity) begin
          state_d = ST_IDLE;
        end else if (sh_q[{1'b0, idx_q}] != sh_q[{1'b1, idx_q}]) begin
          state_d = ST_DONE;
          pass_d  = 1'b0;
          mis_d   = idx_q;
          err_d   = 1'b1;
        end else if (idx_q == 4'd15) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
`ifdef QED_CHECK_STICKY_EN
          err_d   = err_q;
`else
          err_d   = 1'b0;
`endif
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      // NOTE: the shadow file is cleared on reset so a scan never compares stale contents.
      sh_q    <= '{default: '0};
      orig_q  <= '0;
      dup_q   <= '0;
      ovf_q   <= 1'b0;
      dirty_q <= 1'b0;
      idx_q   <= '0;
      mis_q   <= '0;
      pass_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      orig_q  <= orig_d;
      dup_q   <= dup_d;
      ovf_q   <= ovf_d;
      dirty_q <= dirty_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign orig_count   = orig_q;
  assign dup_count    = dup_q;
  assign cnt_ovf      = ovf_q;
  assign check_busy   = (state_q == ST_SCAN);
  assign check_done   = (state_q == ST_DONE);
  assign check_pass   = pass_q;
  assign mismatch_idx = mis_q;
  assign qed_error    = err_q;

endmodule
